ram_bank: RTL
=============

# ram_bank

Parametrised successor to the fixed 8×16 register RAM. It provides a 2^ADDR_W × WIDTH memory with a synchronous write and a registered read. A built-in clear sequencer zeroes every word after reset or on request, and a busy flag tells the datapath when the bank can accept accesses. It sits in the same memory hierarchy as the register RAMs and serves as the standard storage bank for wider or deeper data paths.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- ADDR_W, 3, address width; depth DEPTH = 2^ADDR_W (derived, not overridable)

- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in  input  WIDTH  write data
- addr  input  ADDR_W  word address for read or write
- write  input  1  write strobe; writes in to mem[addr] at the edge
- read  input  1  read strobe; mem[addr] appears on out after the edge
- clear  input  1  request to zero all words
- out  output  WIDTH  registered read data
- out_valid  output  1  high for one cycle per accepted read
- busy  output  1  high while the clear sequencer runs; accesses are ignored

## Operation
- FSM has two states: CLEAR and IDLE.
- rst_n low (asynchronous):
  - FSM enters CLEAR with clear counter = 0.
  - Outputs: out = 0, out_valid = 0, busy = 1.
  - Memory array is not reset directly; the sequencer zeroes it.
- CLEAR state:
  - Each cycle, mem[counter] is written with 0 and the counter increments.
  - After writing word DEPTH-1, the FSM goes to IDLE and the counter wraps to 0.
  - write, read and clear inputs are ignored.
  - out holds 0 and out_valid = 0.
- IDLE state:
  - write=1: mem[addr] ← in at the edge.
  - read=1: out ← mem[addr] at the edge and out_valid = 1 for that cycle.
  - read=0: out holds its last value and out_valid = 0.
  - write and read together at the same addr (write-first): out ← in, and mem[addr] ← in.
  - write and read together at different addresses: both are performed.
  - clear=1: FSM enters CLEAR at the edge with counter = 0. clear has priority, so a write or read in that same cycle is dropped, and out_valid is 0 the next cycle.
- clear asserted while already in CLEAR has no effect: no restart, no extension.
- Width rules: the counter is ADDR_W+1 bits wide or uses a terminal-count compare at DEPTH-1. No addr value is out of range.

## Timing
- Write latency: data is visible to a read issued on the next cycle.
- Read latency is 1 cycle: a read accepted at edge N gives out and out_valid valid after edge N, until edge N+1.
- Clear duration:
  - busy is high for exactly DEPTH cycles after release of rst_n, or after the edge that samples clear.
  - busy rises at the edge that samples clear, or asynchronously with rst_n.
  - busy falls at the edge that writes word DEPTH-1; accesses are accepted on the next edge.
- Reset mid-clear: the sequence restarts from word 0 and the full DEPTH cycles apply again.
- Reset mid-read: out and out_valid drop to 0 immediately (asynchronously).
- Back-to-back reads at successive addresses produce one valid word per cycle, with no bubbles.

## Test plan
- Defaults; release rst_n → busy=1 for exactly 8 cycles. Then read addrs 0..7 → out=0x0000 with out_valid=1 each cycle.
- Write 0xBEEF @5. Next cycle read @5 → out=0xBEEF, out_valid=1 one cycle after the read strobe. Read @4 → 0x0000.
- Same cycle write 0x1234 @2 and read @2 → out=0x1234 next cycle. Later read @2 → 0x1234.
- Write 0xAAAA @0..7 and then pulse clear, holding write=1 at data 0x5555 @3 during busy:
  - busy is high 8 cycles.
  - All words read 0x0000 afterwards (the held write is ignored).
  - out_valid stays 0 during busy.
- Pulse rst_n low at clear-count 4 → out=0 and busy=1 immediately. The clear restarts and busy lasts the full 8 cycles.
- WIDTH=32, ADDR_W=6: busy lasts 64 cycles. Write 0xDEADBEEF @63 and read it back → 0xDEADBEEF. Read @0 → 0.

Source files
------------

// File: rtl/ram_bank.sv
// ram_bank: 2^ADDR_W x WIDTH storage bank with a synchronous write port and
// a registered read port. A clear sequencer zeroes one word per cycle after
// reset or on request, and busy is high while it runs. Accesses presented
// while busy, or in the same cycle as a clear request, are dropped.
module ram_bank #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic              read,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  // Depth follows from the address width and cannot be set independently.
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clear_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              idle;
  logic              last_word;
  logic              accept;
  logic              do_write;
  logic              do_read;
  logic [WIDTH-1:0]  rd_data_p0;
  logic [WIDTH-1:0]  rd_data_p1;
  logic              vld_p1;

  // Terminal count at DEPTH-1: the all-ones counter value.
  function automatic logic is_last(input logic [ADDR_W-1:0] cnt);
    return &cnt;
  endfunction

  // Write-first merge: a write in the same cycle as a read (one shared
  // address) forwards the incoming data instead of the stale word.
  function automatic logic [WIDTH-1:0] read_merge(
    input logic             wr,
    input logic [WIDTH-1:0] wdata,
    input logic [WIDTH-1:0] mdata
  );
    return wr ? wdata : mdata;
  endfunction

  assign idle      = (state == IDLE);
  assign last_word = is_last(clear_cnt);
  // clear takes priority over any access sampled on the same edge.
  assign accept    = idle & ~clear;
  assign do_write  = accept & write;
  assign do_read   = accept & read;
  assign busy      = ~idle;

  assign rd_data_p0 = read_merge(write, in, mem[addr]);

  // Sequencer: step through every word in CLEAR, return to IDLE after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clear_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clear_cnt <= clear_cnt + 1'b1;
          if (last_word) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (clear) begin
            state     <= CLEAR;
            clear_cnt <= '0;
          end
        end
        default: begin
          state     <= CLEAR;
          clear_cnt <= '0;
        end
      endcase
    end
  end

  // Storage array: zeroed word by word while clearing, else the write port.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[clear_cnt] <= '0;
    end else if (do_write) begin
      mem[addr] <= in;
    end
  end

  // ---- stage p0 -> p1: registered read data and its valid flag ----
  // Read register: zero while clearing or on a clear request, hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (!accept) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= do_read;
      if (do_read) begin
        rd_data_p1 <= rd_data_p0;
      end
    end
  end

  assign out       = rd_data_p1;
  assign out_valid = vld_p1;

endmodule
